// File: rtl/writeback_arb.sv
// Writeback arbiter: per-source FIFOs (alu, mem), round-robin grant, registered regfile write port.
// Optional operand forwarding from the write port is enabled by defining WRITEBACK_BYPASS_EN.
module writeback_arb #(
    parameter int width_p = 32,
    parameter int depth_p = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               alu_v_i,
    input  logic [4:0]         alu_rd_i,
    input  logic [width_p-1:0] alu_data_i,
    output logic               alu_ready_o,
    input  logic               mem_v_i,
    input  logic [4:0]         mem_rd_i,
    input  logic [width_p-1:0] mem_data_i,
    output logic               mem_ready_o,
    output logic               writeback_rd_w_v_o,
    output logic [4:0]         writeback_rd_o,
    output logic [width_p-1:0] writeback_rd_data_o,
`ifdef WRITEBACK_BYPASS_EN
    input  logic [4:0]         rs1_i,
    input  logic [4:0]         rs2_i,
    output logic               rs1_fwd_v_o,
    output logic               rs2_fwd_v_o,
    output logic [width_p-1:0] rs1_fwd_data_o,
    output logic [width_p-1:0] rs2_fwd_data_o,
`endif
    output logic               idle_o
);

    localparam int ptr_w_lp   = $clog2(depth_p);
    localparam int cnt_w_lp   = ptr_w_lp + 1;
    localparam int num_src_lp = 2;
    localparam logic [cnt_w_lp-1:0] depth_cnt_lp = cnt_w_lp'(depth_p);

    typedef struct packed {
        logic [4:0]         rd;
        logic [width_p-1:0] data;
    } wb_entry_t;

    // Source index 0 is alu, 1 is mem.
    wb_entry_t             fifo_mem  [num_src_lp][depth_p];
    logic [ptr_w_lp-1:0]   wr_ptr    [num_src_lp];
    logic [ptr_w_lp-1:0]   rd_ptr    [num_src_lp];
    logic [cnt_w_lp-1:0]   cnt       [num_src_lp];
    wb_entry_t             src_entry [num_src_lp];
    logic [num_src_lp-1:0] src_v;
    logic [num_src_lp-1:0] ready;
    logic [num_src_lp-1:0] push;
    logic [num_src_lp-1:0] pop;
    logic [num_src_lp-1:0] not_empty;

    logic      grant_v;
    logic      grant_src;
    logic      alu_pri_q;
    wb_entry_t head;
    logic      wb_v_q;
    wb_entry_t wb_q;

    always_comb begin
        // NOTE: every signal written here gets a value before any branch, so no latch is inferred.
        src_v        = {mem_v_i, alu_v_i};
        src_entry[0] = '{rd: alu_rd_i, data: alu_data_i};
        src_entry[1] = '{rd: mem_rd_i, data: mem_data_i};
        ready        = '0;
        push         = '0;
        not_empty    = '0;
        pop          = '0;
        for (int s = 0; s < num_src_lp; s++) begin
            ready[s]     = !rst_i && (cnt[s] < depth_cnt_lp);
            push[s]      = src_v[s] && ready[s];
            not_empty[s] = (cnt[s] != '0);
        end
        // Contended: the source not granted last time wins; otherwise the only non-empty one.
        grant_v   = |not_empty;
        grant_src = (&not_empty) ? ~alu_pri_q : ~not_empty[0];
        if (grant_v) begin
            pop[grant_src] = 1'b1;
        end
        head = fifo_mem[grant_src][rd_ptr[grant_src]];
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int s = 0; s < num_src_lp; s++) begin
                wr_ptr[s] <= '0;
                rd_ptr[s] <= '0;
                cnt[s]    <= '0;
            end
            alu_pri_q <= 1'b1;
            wb_v_q    <= 1'b0;
            wb_q      <= '0;
        end else begin
            for (int s = 0; s < num_src_lp; s++) begin
                if (push[s]) wr_ptr[s] <= wr_ptr[s] + ptr_w_lp'(1);
                if (pop[s])  rd_ptr[s] <= rd_ptr[s] + ptr_w_lp'(1);
                case ({push[s], pop[s]})
                    2'b10:   cnt[s] <= cnt[s] + cnt_w_lp'(1);
                    2'b01:   cnt[s] <= cnt[s] - cnt_w_lp'(1);
                    default: cnt[s] <= cnt[s];
                endcase
            end
            if (grant_v) begin
                alu_pri_q <= grant_src;
                wb_q      <= head;
                wb_v_q    <= (head.rd != 5'd0);
            end else begin
                wb_v_q    <= 1'b0;
            end
        end
    end

    // NOTE: FIFO storage is not reset; pointers and counts alone decide which entries are live.
    always_ff @(posedge clk_i) begin
        for (int s = 0; s < num_src_lp; s++) begin
            if (push[s]) fifo_mem[s][wr_ptr[s]] <= src_entry[s];
        end
    end

    assign alu_ready_o         = ready[0];
    assign mem_ready_o         = ready[1];
    assign writeback_rd_w_v_o  = wb_v_q && !rst_i;
    assign writeback_rd_o      = rst_i ? 5'd0 : wb_q.rd;
    assign writeback_rd_data_o = rst_i ? '0 : wb_q.data;
    assign idle_o              = !rst_i && (not_empty == '0) && !wb_v_q;

`ifdef WRITEBACK_BYPASS_EN
    always_comb begin
        rs1_fwd_v_o    = writeback_rd_w_v_o && (rs1_i != 5'd0) && (writeback_rd_o == rs1_i);
        rs2_fwd_v_o    = writeback_rd_w_v_o && (rs2_i != 5'd0) && (writeback_rd_o == rs2_i);
        rs1_fwd_data_o = rs1_fwd_v_o ? writeback_rd_data_o : '0;
        rs2_fwd_data_o = rs2_fwd_v_o ? writeback_rd_data_o : '0;
    end
`endif

endmodule
